// File: rtl/clocked_delay_line_if.sv
// Channel, configuration and status signals of clocked_delay_line.
// master drives din/cfg/drop_clr; slave (the delay line) returns dout/drop_flag/cfg_err.
interface clocked_delay_line_if #(
    parameter int CH       = 4,
    parameter int CH_IDX_W = 2,
    parameter int DLY_W    = 4
);
    logic [CH-1:0]       din;
    // cfg_we is a single-cycle strobe with no back-pressure: a write is taken
    // on every edge it is high, and a bad channel index is answered by cfg_err.
    logic                cfg_we;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [DLY_W-1:0]    cfg_dly;
    logic                cfg_mode;
    logic                drop_clr;
    logic [CH-1:0]       dout;
    logic [CH-1:0]       drop_flag;
    logic                cfg_err;

    modport master (
        output din, cfg_we, cfg_ch, cfg_dly, cfg_mode, drop_clr,
        input  dout, drop_flag, cfg_err
    );

    modport slave (
        input  din, cfg_we, cfg_ch, cfg_dly, cfg_mode, drop_clr,
        output dout, drop_flag, cfg_err
    );
endinterface

// File: rtl/clocked_delay_line.sv
// CH independent 1-bit delay channels, each either a transport shift line or an
// inertial glitch filter, with runtime-programmable delay and sticky drop flags.
module clocked_delay_line #(
    parameter int CH       = 4,
    parameter int CH_IDX_W = 2,
    parameter int DLY_W    = 4,
    parameter int DEF_DLY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    clocked_delay_line_if.slave  bus
);
    localparam int MAX_DLY = 2**DLY_W - 1;
    // dout is its own flop, so the shift line only needs MAX_DLY-1 stages.
    localparam int SR_W    = MAX_DLY - 1;

    logic [SR_W-1:0]  sr      [CH];
    logic [DLY_W-1:0] dly     [CH];
    logic [DLY_W-1:0] cnt     [CH];
    logic [CH-1:0]    mode;
    logic [CH-1:0]    dout_q;
    logic [CH-1:0]    drop_q;
    logic             cfg_err_q;

    logic [DLY_W-1:0] deff    [CH];
    logic [DLY_W-1:0] tap_idx [CH];
    logic [CH-1:0]    tap;
    logic [CH-1:0]    hit;
    logic [CH-1:0]    drop_ev;
    logic [CH_IDX_W:0] cfg_ch_ext;
    logic             cfg_valid;

    assign cfg_ch_ext = {1'b0, bus.cfg_ch};
    assign cfg_valid  = cfg_ch_ext < (CH_IDX_W + 1)'(CH);

    always_comb begin
        tap     = '0;
        hit     = '0;
        drop_ev = '0;
        for (int c = 0; c < CH; c++) begin
            deff[c]    = (dly[c] == '0) ? DLY_W'(1) : dly[c];
            tap_idx[c] = deff[c] - DLY_W'(2);
            tap[c]     = (deff[c] == DLY_W'(1)) ? bus.din[c] : sr[c][tap_idx[c]];
            hit[c]     = bus.cfg_we && (cfg_ch_ext == (CH_IDX_W + 1)'(c));
            // A run of mismatching samples that ended before reaching Deff.
            drop_ev[c] = !hit[c] && mode[c] && (bus.din[c] == dout_q[c])
                         && (cnt[c] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
            dout_q    <= '0;
            drop_q    <= '0;
            mode      <= '0;
            for (int c = 0; c < CH; c++) begin
                sr[c]  <= '0;
                dly[c] <= DLY_W'(DEF_DLY);
                cnt[c] <= '0;
            end
        end else begin
            cfg_err_q <= bus.cfg_we && !cfg_valid;
            drop_q    <= (drop_q & ~{CH{bus.drop_clr}}) | drop_ev;
            for (int c = 0; c < CH; c++) begin
                if (hit[c]) begin
                    // Flush: fill the line with the held output so dout stays glitch-free.
                    dly[c]  <= bus.cfg_dly;
                    mode[c] <= bus.cfg_mode;
                    sr[c]   <= {SR_W{dout_q[c]}};
                    cnt[c]  <= '0;
                end else begin
                    sr[c] <= {sr[c][SR_W-2:0], bus.din[c]};
                    if (!mode[c]) begin
                        dout_q[c] <= tap[c];
                        cnt[c]    <= '0;
                    end else if (bus.din[c] != dout_q[c]) begin
                        if (cnt[c] + DLY_W'(1) == deff[c]) begin
                            dout_q[c] <= bus.din[c];
                            cnt[c]    <= '0;
                        end else begin
                            cnt[c] <= cnt[c] + DLY_W'(1);
                        end
                    end else begin
                        cnt[c] <= '0;
                    end
                end
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.drop_flag = drop_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule
